fb_scanout: RTL and testbench
=============================

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, pixel ticks per line.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have parameter CLEAR_COLOUR, default 3'b000, colour written by clear.
REQ-006 clk  input  1  single 50 MHz clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 plot  input  1  pixel write strobe, one write per cycle.
REQ-009 x  input  8  write column, 0..159.
REQ-010 y  input  7  write row, 0..119.
REQ-011 colour  input  3  write colour {R,G,B}.
REQ-012 clear  input  1  single-cycle request to fill the framebuffer with CLEAR_COLOUR.
REQ-013 busy  output  1  high while clear is in progress.
REQ-014 vga_r, vga_g, vga_b  output  1 each  pixel colour; 0 outside the visible area.
REQ-015 vga_hs, vga_vs  output  1 each  active-low sync.
REQ-016 vga_blank_n  output  1  high in the visible area only.
REQ-017 pix_en  output  1  pixel tick; high every second clk cycle.
REQ-018 frame_start  output  1  one-clk pulse on the tick where h=0, v=V_VISIBLE (start of vertical blank).

Function
REQ-019 Framebuffer SHALL be 160x120 entries of 3 bits, address y*160+x.
REQ-020 plot with x<160 and y<120 and busy=0 SHALL write colour the same cycle; out-of-range or busy writes are dropped silently.
REQ-021 pix_en SHALL toggle every clk cycle; h/v counters advance only on pix_en.
REQ-022 h SHALL wrap H_TOTAL-1 -> 0 and increment v; v SHALL wrap V_TOTAL-1 -> 0.
REQ-023 vga_hs SHALL be low for h in 656..751; vga_vs low for v in 490..491.
REQ-024 Read address SHALL be (v>>2)*160+(h>>2); each stored pixel is replicated 4x4.
REQ-025 Framebuffer read latency is 1 clk; hs/vs/blank_n SHALL be delayed so all VGA outputs stay mutually aligned (total pipeline 2 clk from counter to pins).
REQ-026 Simultaneous write and read of the same address SHALL return the old data (read-before-write).
REQ-027 Clear FSM states IDLE -> CLEARING -> IDLE: clear in IDLE enters CLEARING, writes CLEAR_COLOUR to addresses 0..19199, one per clk, then returns to IDLE; busy=1 in CLEARING exactly 19200 cycles.
REQ-028 clear asserted during CLEARING SHALL be ignored (no restart).
REQ-029 Scan-out SHALL continue unaffected during clear.

Reset
REQ-030 reset SHALL force h=0, v=0, pix_en=0, clear FSM to IDLE, busy=0, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0.
REQ-031 Framebuffer contents SHALL NOT be reset; reset mid-clear abandons the clear, leaving partial contents.

Structure
REQ-032 Timing constants (sync start/end, totals) and FB_W=160, FB_H=120 SHALL live in a shared package.
REQ-033 Storage SHALL be a sub-module fb_ram: simple dual-port, 1 write port, 1 registered read port.

Verification
REQ-034 Write plot x=5,y=3,colour=3'b101; scan frame -> RGB=101 for h=20..23, v=12..15, 0 elsewhere in that region.
REQ-035 plot x=160,y=0 and x=0,y=120 -> no framebuffer change; address 0 still reads prior value.
REQ-036 Free-run after reset -> hs period 1600 clk, low 192 clk; vs period 840000 clk, low 3200 clk; one frame_start per frame.
REQ-037 clear with CLEAR_COLOUR=3'b010 -> busy high 19200 cycles, plots during busy dropped, full frame reads 010.
REQ-038 Assert reset at clear cycle 100 -> busy=0 next edge, sync outputs at reset values, addresses >=100 retain old data.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared constants for the 160x120 framebuffer and VGA scan-out timing.
package fb_scanout_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = 15;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_TOTAL_DEF   = 800;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_TOTAL_DEF   = 525;

  // Sync pulses sit a fixed front porch after the visible area: 656..751 and 490..491 by default.
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;

  typedef enum logic {CLR_IDLE, CLR_CLEARING} clr_state_t;

  function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return FB_AW'(row) * FB_AW'(FB_W) + FB_AW'(col);
  endfunction

endpackage

// File: rtl/fb_scanout_ram.sv
// Simple dual-port framebuffer store: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module fb_ram
  import fb_scanout_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FB_AW-1:0] waddr,
  input  logic [2:0]       wdata,
  input  logic [FB_AW-1:0] raddr,
  output logic [2:0]       rdata
);

  logic [2:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_scanout.sv
// 160x120x3 framebuffer with 4x4-replicated VGA scan-out and a clear engine.
// state        | meaning
// CLR_IDLE     | plots accepted, waiting for clear
// CLR_CLEARING | writing CLEAR_COLOUR to one address per clk, plots dropped
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int         H_VISIBLE    = H_VISIBLE_DEF,
  parameter int         H_TOTAL      = H_TOTAL_DEF,
  parameter int         V_VISIBLE    = V_VISIBLE_DEF,
  parameter int         V_TOTAL      = V_TOTAL_DEF,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       busy,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       pix_en,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_DEPTH - 1);

  logic [9:0]       h, v;
  clr_state_t       clr_state;
  logic [FB_AW-1:0] clr_addr;
  logic             vis_0, hs_0, vs_0, in_range;
  logic             vis_d1, hs_d1, vs_d1;
  logic [FB_AW-1:0] rd_addr, wr_addr;
  logic [2:0]       rd_data, wr_data;
  logic             wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign frame_start = pix_en && (h == '0) && (v == V_VIS_L);

  assign vis_0   = (h < H_VIS_L) && (v < V_VIS_L);
  assign hs_0    = !((h >= HS_START) && (h < HS_END));
  assign vs_0    = !((v >= VS_START) && (v < VS_END));
  assign rd_addr = vis_0 ? fb_addr(7'(v >> 2), 8'(h >> 2)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state <= CLR_IDLE;
      busy      <= 1'b0;
      clr_addr  <= '0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clear) begin
            clr_state <= CLR_CLEARING;
            busy      <= 1'b1;
            clr_addr  <= '0;
          end
        end
        CLR_CLEARING: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == FB_LAST) begin
            clr_state <= CLR_IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  // The clear engine owns the write port outright while busy.
  assign in_range = (x < 8'(FB_W)) && (y < 7'(FB_H));
  assign wr_en    = busy || (plot && in_range);
  assign wr_addr  = busy ? clr_addr : fb_addr(y, x);
  assign wr_data  = busy ? CLEAR_COLOUR : colour;

  fb_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Syncs and blank ride alongside the RAM read so everything reaches the pins together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      vga_r       <= 1'b0;
      vga_g       <= 1'b0;
      vga_b       <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vis_d1      <= vis_0;
      hs_d1       <= hs_0;
      vs_d1       <= vs_0;
      vga_r       <= vis_d1 && rd_data[2];
      vga_g       <= vis_d1 && rd_data[1];
      vga_b       <= vis_d1 && rd_data[0];
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      vga_blank_n <= vis_d1;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: reset, clear, plots, one scanned frame, reset mid-clear.
// Frame height is shortened so a whole frame including vertical sync fits in the run.
module tb_fb_scanout;

  localparam int HV = 640;
  localparam int HT = 800;
  localparam int VV = 16;
  localparam int VT = 28;
  localparam int F  = HT * VT;
  localparam logic [2:0] CLR = 3'b010;

  logic       clk = 1'b0;
  logic       reset, plot, clear;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, pix_en, frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] fb_model [19200];
  logic [2:0] cap [16][640];

  fb_scanout #(
    .H_VISIBLE    (HV),
    .H_TOTAL      (HT),
    .V_VISIBLE    (VV),
    .V_TOTAL      (VT),
    .CLEAR_COLOUR (CLR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .clear       (clear),
    .busy        (busy),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .pix_en      (pix_en),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_plot(input int px, input int py, input logic [2:0] c);
    x = 8'(px);
    y = 7'(py);
    colour = c;
    plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
    if (px < 160 && py < 120) fb_model[py*160 + px] = c;
  endtask

  function automatic int rgb();
    return int'({vga_r, vga_g, vga_b});
  endfunction

  int   cnt, q, hh, vv, errs;
  int   err_blank, err_hs, err_vs, err_off, err_on;
  int   fall1, fall2, hs_low, vs_low, fs_cnt, fs_n;
  logic vis, exp_hs, exp_vs, hs_prev;

  initial begin
    reset = 1'b1; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank_n", vga_blank_n, 0);
    check("rst_rgb", rgb(), 0);
    check("rst_pix_en", pix_en, 0);
    check("rst_frame_start", frame_start, 0);

    reset = 1'b0;
    @(negedge clk);
    check("pix_en_first", pix_en, 1);
    @(negedge clk);
    check("pix_en_second", pix_en, 0);

    // clear: busy length, ignored re-request, dropped plot into an already-cleared address
    for (int a = 0; a < 19200; a++) fb_model[a] = CLR;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("busy_after_clear", busy, 1);
    cnt = 0;
    while (busy && cnt < 20000) begin
      plot = (cnt == 10000);
      x = 8'd10; y = 7'd2; colour = 3'b111;
      clear = (cnt == 50);
      @(negedge clk);
      cnt++;
    end
    plot = 1'b0; clear = 1'b0;
    check("clear_busy_cycles", cnt, 19200);

    do_plot(5, 3, 3'b101);
    do_plot(0, 0, 3'b011);
    do_plot(160, 0, 3'b110);
    do_plot(0, 120, 3'b110);
    do_plot(159, 3, 3'b001);

    // one full frame from reset; pins after edge n show pixel (n-2)/2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_blank = 0; err_hs = 0; err_vs = 0; err_off = 0; err_on = 0;
    fall1 = -1; fall2 = -1; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_n = -1;
    hs_prev = 1'b1;
    for (int n = 1; n <= 2*F + 1; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        q  = (n - 2) / 2;
        hh = q % HT;
        vv = q / HT;
        vis    = (hh < HV) && (vv < VV);
        exp_hs = !(hh >= 656 && hh < 752);
        exp_vs = !(vv >= 26 && vv < 28);
        if (vga_blank_n != vis) err_blank++;
        if (vga_hs != exp_hs) err_hs++;
        if (vga_vs != exp_vs) err_vs++;
        if (!vis && rgb() != 0) err_off++;
        if (vis) begin
          if (rgb() != int'(fb_model[(vv/4)*160 + hh/4])) err_on++;
          if (n % 2 == 0) cap[vv][hh] = 3'(rgb());
        end
      end
      if (hs_prev && !vga_hs) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      if (fall1 >= 0 && fall2 < 0 && !vga_hs) hs_low++;
      hs_prev = vga_hs;
      if (!vga_vs) vs_low++;
      if (frame_start) begin
        fs_cnt++;
        fs_n = n;
      end
    end
    check("frame_blank_errs", err_blank, 0);
    check("frame_hs_errs", err_hs, 0);
    check("frame_vs_errs", err_vs, 0);
    check("frame_rgb_blank_errs", err_off, 0);
    check("frame_rgb_visible_errs", err_on, 0);
    check("hs_period", fall2 - fall1, 1600);
    check("hs_low", hs_low, 192);
    check("vs_low", vs_low, 3200);
    check("frame_start_count", fs_cnt, 1);
    check("frame_start_pos", fs_n, 2*VV*HT + 1);
    check("px_20_12", cap[12][20], 3'b101);
    check("px_23_15", cap[15][23], 3'b101);
    check("px_19_12", cap[12][19], 3'b010);
    check("px_20_11", cap[11][20], 3'b010);
    check("px_24_15", cap[15][24], 3'b010);
    check("px_0_0_after_bad_plots", cap[0][0], 3'b011);
    check("px_0_4_x160_dropped", cap[4][0], 3'b010);
    check("px_40_8_busy_plot_dropped", cap[8][40], 3'b010);
    check("px_639_12_x159", cap[12][639], 3'b001);

    // reset at clear cycle 100 leaves addresses >= 100 untouched
    for (int i = 0; i < 160; i++) do_plot(i, 0, 3'b111);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("midclear_cycles", cnt, 100);
    reset = 1'b1;
    #1;
    check("midclear_busy", busy, 0);
    check("midclear_hs", vga_hs, 1);
    check("midclear_vs", vga_vs, 1);
    check("midclear_blank_n", vga_blank_n, 0);
    check("midclear_rgb", rgb(), 0);
    @(posedge clk);
    #1;
    check("midclear_busy_next_edge", busy, 0);
    for (int a = 0; a < 100; a++) fb_model[a] = CLR;
    @(negedge clk);
    reset = 1'b0;

    // line 0 scan with a same-cycle write to the address being read at h=200
    for (int n = 1; n <= 1281; n++) begin
      @(negedge clk);
      if (n >= 2 && n % 2 == 0) cap[0][(n - 2) / 2] = 3'(rgb());
      if (n == 400) begin
        x = 8'd50; y = 7'd0; colour = 3'b100; plot = 1'b1;
      end else begin
        plot = 1'b0;
      end
    end
    plot = 1'b0;
    errs = 0;
    for (int h2 = 0; h2 < 640; h2++)
      if (h2 < 200 || h2 > 203)
        if (cap[0][h2] != fb_model[h2/4]) errs++;
    check("line0_errs", errs, 0);
    check("line0_x99", cap[0][396], 3'b010);
    check("line0_x100", cap[0][400], 3'b111);
    check("line0_x159", cap[0][639], 3'b111);
    check("rbw_old_data", cap[0][200], 3'b010);
    check("rbw_new_data", cap[0][201], 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
